// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU fetch port (I) and
// the load/store port (D). Ties are broken round-robin, and only one access is
// in flight at a time. The request is captured into registers before it goes
// to memory. A watchdog aborts a memory access that never acks and returns an
// error to the owning master.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    output logic            i_err,
    // load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            d_err,
    // memory port
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    // status
    output logic [1:0]      grant
);

    localparam int SW = DW / 8;
    // Watchdog width: $clog2(TIMEOUT+1). Keep at least one bit when the
    // watchdog is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Last count value seen before the abort fires. At that point m_req has
    // been high for TIMEOUT cycles.
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit WD_EN = (TIMEOUT != 0);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Captured memory request: everything the memory port presents while BUSY.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } mreq_t;

    state_t        state, state_nxt;
    logic          owner;       // master that owns the current transaction
    logic          last_owner;  // owner of the previous transaction, for tie-break
    mreq_t         req_q;
    mreq_t         req_sel;
    logic          m_req_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [CW-1:0] wd_cnt;

    logic          grant_vld;
    logic          grant_d;
    logic          wd_fire;
    logic          resp_i;
    logic          resp_d;

    // State register. An asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, arbitration decision and watchdog abort.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_d   = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_vld = 1'b1;
                    // D wins when it is the only requester. On a tie it wins
                    // when I owned the bus last.
                    grant_d   = d_req && (!i_req || (last_owner == OWN_I));
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A real ack always beats the watchdog in the same cycle.
                if (m_ack) begin
                    state_nxt = RESP;
                end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                    wd_fire   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Mux the winning master's request fields. Fetches are reads with no strobes.
    always_comb begin
        req_sel = '0;
        if (grant_d) begin
            req_sel.we    = d_we;
            req_sel.addr  = d_addr;
            req_sel.wdata = d_wdata;
            req_sel.wstrb = d_wstrb;
        end else begin
            req_sel.we    = 1'b0;
            req_sel.addr  = i_addr;
            req_sel.wdata = '0;
            req_sel.wstrb = '0;
        end
    end

    // Capture the request on grant, hold m_req through BUSY, and track ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_I;
            last_owner <= OWN_I;
            req_q      <= '0;
            m_req_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner   <= grant_d ? OWN_D : OWN_I;
                        req_q   <= req_sel;
                        m_req_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (m_ack || wd_fire) m_req_q <= 1'b0;
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

    // Latch the response: memory data on ack (zero for writes), or an error on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == BUSY) begin
            if (m_ack) begin
                rdata_q <= req_q.we ? '0 : m_rdata;
                err_q   <= 1'b0;
            end else if (wd_fire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Watchdog: count cycles with m_req high in BUSY; clear everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                wd_cnt <= '0;
        else if (WD_EN && state == BUSY && m_req_q) wd_cnt <= wd_cnt + 1'b1;
        else                                       wd_cnt <= '0;
    end

    // Only the owner sees ack/err/rdata, and only during its RESP cycle.
    always_comb begin
        resp_i  = (state == RESP) && (owner == OWN_I);
        resp_d  = (state == RESP) && (owner == OWN_D);
        i_ack   = resp_i;
        i_err   = resp_i & err_q;
        i_rdata = resp_i ? rdata_q : '0;
        d_ack   = resp_d;
        d_err   = resp_d & err_q;
        d_rdata = resp_d ? rdata_q : '0;
    end

    // Memory port and grant status. All are driven from registers.
    always_comb begin
        m_req   = m_req_q;
        m_we    = req_q.we;
        m_addr  = req_q.addr;
        m_wdata = req_q.wdata;
        m_wstrb = req_q.wstrb;
        if (state == IDLE) grant = 2'b00;
        else               grant = (owner == OWN_D) ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven transactions with a scoreboard queue, plus
// hand-written sequences for the tie, reset-abort and spurious-ack cases.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [31:0]   i_rdata;
    logic          i_ack, i_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic [31:0]   d_rdata;
    logic          d_ack, d_err;
    logic          m_req, m_we;
    logic [31:0]   m_addr, m_wdata;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_rdata;
    logic          m_ack;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant)
    );

    // Memory model: acks on the mem_wait-th m_req cycle (0 = never acks).
    int          mem_wait = 1;
    logic [31:0] mem_data = '0;
    logic        force_ack = 1'b0;
    int          mcnt = 0;
    always @(posedge clk) mcnt <= m_req ? mcnt + 1 : 0;
    assign m_ack   = force_ack | (m_req && (mem_wait != 0) && (mcnt == mem_wait - 1));
    assign m_rdata = mem_data;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
        int          mcyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: check the m_* fields when m_req rises, then pop and check on ack.
    bit in_xfer = 0;
    int mcyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_xfer = 0;
            mcyc = 0;
        end else begin
            if (m_req) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    mcyc = 0;
                    if (exp_q.size() == 0) chk("unexpected_mreq", m_req, 0);
                    else begin
                        e = exp_q[0];
                        chk("m_addr", m_addr, e.addr);
                        chk("m_we", m_we, e.we);
                        chk("m_wstrb", m_wstrb, e.wstrb);
                        if (e.is_d) chk("m_wdata", m_wdata, e.wdata);
                        chk("grant_busy", grant, e.is_d ? 2'b10 : 2'b01);
                    end
                end
                mcyc++;
            end
            if (i_ack || d_ack) begin
                if (exp_q.size() == 0) chk("unexpected_ack", {i_ack, d_ack}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_master", {d_ack, i_ack}, e.is_d ? 2'b10 : 2'b01);
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                    chk("err", e.is_d ? d_err : i_err, e.err);
                    chk("other_rsp", e.is_d ? {i_rdata, i_err} : {d_rdata, d_err}, 0);
                    chk("mreq_cycles", mcyc, e.mcyc);
                    chk("grant_resp", grant, e.is_d ? 2'b10 : 2'b01);
                end
                in_xfer = 0;
            end
        end
    end

    // Drive one transaction from IDLE. Wait for its ack, then return in IDLE.
    task automatic xfer(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] mdata, input int mwait,
                        input logic [31:0] exp_rdata, input bit exp_err, input bit spur);
        exp_t e;
        int   lat;
        bit   got;
        e.is_d  = is_d;
        e.we    = is_d & we;
        e.addr  = addr;
        e.wdata = wdata;
        e.wstrb = is_d ? wstrb : 4'h0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.mcyc  = (mwait != 0) ? mwait : TO;
        exp_q.push_back(e);
        mem_wait = mwait;
        mem_data = mdata;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        end else begin
            i_req = 1; i_addr = addr;
        end
        lat = 0;
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (i_ack || d_ack) got = 1;
        end
        i_req = 0;
        d_req = 0;
        chk("ack_seen", got, 1);
        if (got) chk("latency", lat, (mwait != 0) ? mwait + 1 : TO + 1);
        else exp_q.delete();
        if (spur) begin
            // Pulse m_ack during the RESP cycle. It must be ignored.
            force_ack = 1;
            @(negedge clk);
            force_ack = 0;
            chk("spur_resp", {grant, m_req, i_ack, d_ack}, 0);
        end else begin
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] mdata;
        int          mwait;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          spur;
    } vec_t;
    vec_t vecs[9];

    initial begin
        exp_t e;
        int   t[4];
        int   n;
        int   cyc;

        // is_d we addr wdata wstrb mdata mwait exp_rdata exp_err spur
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0000_0013, 2,  32'h0000_0013, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'h5555_AAAA, 1,  32'h0,         1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'hF, 32'hCAFE_F00D, 3,  32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'h0, 32'hBAD0_BAD0, 0,  32'h0,         1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h1234_5678, 1,  32'h1234_5678, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 4'hF, 32'h1111_1111, 16, 32'h0,         1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         4'h5, 32'hA5A5_A5A5, 15, 32'hA5A5_A5A5, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,         4'h0, 32'h0000_0099, 1,  32'h0000_0099, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {m_req, m_we, grant, i_ack, d_ack, i_err, d_err}, 0);
        chk("rst_mfields", {m_addr, m_wstrb}, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst_n = 1;
        @(negedge clk);

        for (int v = 0; v < 9; v++)
            xfer(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb,
                 vecs[v].mdata, vecs[v].mwait, vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].spur);

        // Spurious m_ack while IDLE
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        chk("spur_idle0", {grant, m_req, i_ack, d_ack}, 0);
        @(negedge clk);
        chk("spur_idle1", {grant, m_req, i_ack, d_ack}, 0);

        // Reset mid-BUSY: m_req drops asynchronously, and no ack follows.
        e.is_d = 0; e.we = 0; e.addr = 32'h80; e.wdata = 0; e.wstrb = 0;
        e.rdata = 0; e.err = 0; e.mcyc = 0;
        exp_q.push_back(e);
        mem_wait = 0;
        i_req = 1; i_addr = 32'h80;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", {m_req, grant}, 3'b101);
        #2 rst_n = 0;
        #1 chk("rst_async", {m_req, grant}, 0);
        exp_q.delete();
        i_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_ack", {i_ack, d_ack, m_req}, 0);
        end
        rst_n = 1;
        @(negedge clk);
        xfer(0, 0, 32'h84, 0, 0, 32'h0000_0042, 1, 32'h0000_0042, 0, 0);

        // Both requests held from reset with zero-wait memory: D, I, D, I every 3 cycles.
        @(negedge clk);
        rst_n = 0;
        exp_q.delete();
        mem_wait = 1;
        mem_data = 32'h77;
        i_req = 1; i_addr = 32'h10;
        d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 0; d_wstrb = 0;
        for (int k = 0; k < 4; k++) begin
            e.is_d = (k % 2 == 0); e.we = 0; e.addr = e.is_d ? 32'h20 : 32'h10;
            e.wdata = 0; e.wstrb = 0; e.rdata = 32'h77; e.err = 0; e.mcyc = 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rst_n = 1;
        n = 0;
        cyc = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) begin
                t[n] = cyc;
                n++;
            end
        end
        i_req = 0;
        d_req = 0;
        chk("tie_acks", n, 4);
        if (n == 4) begin
            chk("tie_period0", t[1] - t[0], 3);
            chk("tie_period1", t[2] - t[1], 3);
            chk("tie_period2", t[3] - t[2], 3);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_idle", {grant, m_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
